// File: rtl/lau_pkg.sv
// Shared arithmetic-library definitions: prefix topology selector and
// helpers that size pipelined prefix networks from lane width and topology.
package lau_pkg;

    typedef enum logic [1:0] {FAST, MEDIUM, SLOW} speed_e;

    function automatic int prefix_levels(input int w, input speed_e speed);
        int lg;
        lg = $clog2(w);
        case (speed)
            FAST:    return lg;
            MEDIUM:  return 2 * lg - 1;
            default: return 1;
        endcase
    endfunction

    function automatic int prefix_stages(input int w, input speed_e speed, input int levelsPerStage);
        int lvls;
        lvls = prefix_levels(w, speed);
        return (lvls + levelsPerStage - 1) / levelsPerStage;
    endfunction

endpackage

// File: rtl/prefix_pipe_stage.sv
// One valid/ready register stage of the prefix pipeline, holding G, P and
// (with PREFIX_AND_OR_PIPE_CIN_EN) the per-lane carry-in of its operand.
module prefix_pipe_stage #(
    parameter int width = 32
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
  , parameter int lanes = 1
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             inValid,
    output logic             inReady,
    input  logic [width-1:0] inG,
    input  logic [width-1:0] inP,
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
    input  logic [lanes-1:0] inC,
`endif
    output logic             outValid,
    input  logic             outReady,
    output logic [width-1:0] outG,
    output logic [width-1:0] outP
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
  , output logic [lanes-1:0] outC
`endif
);

    logic load;

    // Accept when empty or when the held entry leaves this cycle; a flush blocks loading.
    assign inReady = !flush_i && (!outValid || outReady);
    assign load    = inValid && inReady;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outValid <= 1'b0;
            outG     <= '0;
            outP     <= '0;
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
            outC     <= '0;
`endif
        end else begin
            if (flush_i)
                outValid <= 1'b0;
            else if (load)
                outValid <= 1'b1;
            else if (outReady)
                outValid <= 1'b0;
            if (load) begin
                outG <= inG;
                outP <= inP;
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
                outC <= inC;
`endif
            end
        end
    end

endmodule

// File: rtl/prefix_and_or_pipe.sv
// Pipelined, lane-segmented parallel-prefix AND-OR carry network.
// Define PREFIX_AND_OR_PIPE_CIN_EN to add the per-lane CI input.
module prefix_and_or_pipe
    import lau_pkg::*;
#(
    parameter int     width          = 32,
    parameter int     lanes          = 1,
    parameter speed_e speed          = FAST,
    parameter int     levelsPerStage = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [width-1:0] GI,
    input  logic [width-1:0] PI,
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
    input  logic [lanes-1:0] CI,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [width-1:0] GO,
    output logic [width-1:0] PO
);

    localparam int laneW     = width / lanes;
    localparam int logW      = $clog2(laneW);
    localparam int numLevels = prefix_levels(laneW, speed);
    localparam int numStages = prefix_stages(laneW, speed, levelsPerStage);
    localparam int lastStage = numStages - 1;

    // One prefix level over every lane. Sources are never updated within their
    // own level, so reading the updated word is safe and makes SLOW a ripple.
    function automatic logic [2*width-1:0] prefixLevel(input logic [width-1:0] g,
                                                       input logic [width-1:0] p,
                                                       input int lvl);
        logic [width-1:0] gn, pn;
        int src, d, b;
        gn = g;
        pn = p;
        for (int j = 0; j < lanes; j++) begin
            for (int i = 1; i < laneW; i++) begin
                src = -1;
                d   = 0;
                case (speed)
                    FAST: if (((i >> lvl) & 1) == 1) src = ((i >> lvl) << lvl) - 1;
                    MEDIUM: begin
                        if (lvl < logW) begin
                            d = 1 << lvl;
                            if ((i + 1) % (2 * d) == 0) src = i - d;
                        end else begin
                            d = 1 << (2 * logW - 2 - lvl);
                            if ((i + 1) % (2 * d) == d) src = i - d;
                        end
                    end
                    default: src = i - 1;
                endcase
                if (src >= 0) begin
                    b     = j * laneW + i;
                    gn[b] = gn[b] | (pn[b] & gn[j * laneW + src]);
                    pn[b] = pn[b] & pn[j * laneW + src];
                end
            end
        end
        return {gn, pn};
    endfunction

    logic [numStages-1:0]            stValid, stReady;
    logic [numStages-1:0][width-1:0] stG, stP;
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
    logic [numStages-1:0][lanes-1:0] stC;
`endif

    for (genvar k = 0; k < numStages; k++) begin : gStage
        localparam int loLvl = k * levelsPerStage;
        localparam int hiLvl = ((k + 1) * levelsPerStage < numLevels) ? (k + 1) * levelsPerStage : numLevels;

        logic [width-1:0]   srcG, srcP, levG, levP;
        logic [2*width-1:0] gp;
        logic               srcValid, dstReady;
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
        logic [lanes-1:0]   srcC;
`endif

        if (k == 0) begin : gFirst
            assign srcG     = GI;
            assign srcP     = PI;
            assign srcValid = valid_i;
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
            assign srcC     = CI;
`endif
        end else begin : gMid
            assign srcG     = stG[k-1];
            assign srcP     = stP[k-1];
            assign srcValid = stValid[k-1];
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
            assign srcC     = stC[k-1];
`endif
        end

        if (k == lastStage) begin : gLast
            assign dstReady = ready_i;
        end else begin : gNext
            assign dstReady = stReady[k+1];
        end

        // Prefix levels loLvl..hiLvl-1 sit in front of this stage's register.
        always_comb begin
            levG = srcG;
            levP = srcP;
            gp   = '0;
            for (int l = loLvl; l < hiLvl; l++) begin
                gp   = prefixLevel(levG, levP, l);
                levG = gp[2*width-1:width];
                levP = gp[width-1:0];
            end
        end

        prefix_pipe_stage #(
            .width(width)
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
          , .lanes(lanes)
`endif
        ) uStage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .inValid (srcValid),
            .inReady (stReady[k]),
            .inG     (levG),
            .inP     (levP),
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
            .inC     (srcC),
`endif
            .outValid(stValid[k]),
            .outReady(dstReady),
            .outG    (stG[k]),
            .outP    (stP[k])
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
          , .outC    (stC[k])
`endif
        );
    end

    assign ready_o = stReady[0];
    assign valid_o = stValid[lastStage];
    assign PO      = stP[lastStage];

`ifdef PREFIX_AND_OR_PIPE_CIN_EN
    // Fold each lane's carry-in into its group terms after the last register.
    always_comb begin
        GO = stG[lastStage];
        for (int j = 0; j < lanes; j++)
            for (int i = 0; i < laneW; i++)
                GO[j*laneW+i] = stG[lastStage][j*laneW+i] | (stP[lastStage][j*laneW+i] & stC[lastStage][j]);
    end
`else
    assign GO = stG[lastStage];
`endif

endmodule

// File: tb/tb_prefix_and_or_pipe.sv
// Directed bench: 8-bit single-lane FAST pipe (3 stages) plus a 2-lane instance (2 stages).
module tb_prefix_and_or_pipe;
    import lau_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, flush;
    logic       valid1, ready1, rdyOut1, validOut1;
    logic [7:0] gi1, pi1, go1, po1;
    logic [0:0] ci1;
    logic       valid2, ready2, rdyOut2, validOut2;
    logic [7:0] gi2, pi2, go2, po2;
    logic [1:0] ci2;
    int         checkCount = 0;
    int         errCount   = 0;

    always #5 clk = ~clk;

    prefix_and_or_pipe #(.width(8), .lanes(1), .speed(FAST), .levelsPerStage(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid1), .ready_o(rdyOut1),
        .GI(gi1), .PI(pi1),
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
        .CI(ci1),
`endif
        .valid_o(validOut1), .ready_i(ready1), .GO(go1), .PO(po1));

    prefix_and_or_pipe #(.width(8), .lanes(2), .speed(FAST), .levelsPerStage(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid2), .ready_o(rdyOut2),
        .GI(gi2), .PI(pi2),
`ifdef PREFIX_AND_OR_PIPE_CIN_EN
        .CI(ci2),
`endif
        .valid_o(validOut2), .ready_i(ready2), .GO(go2), .PO(po2));

    logic [7:0] sG  [10] = '{8'h01, 8'h00, 8'hFF, 8'h10, 8'h01, 8'h00, 8'h81, 8'h02, 8'h05, 8'h20};
    logic [7:0] sP  [10] = '{8'hFE, 8'hFF, 8'h00, 8'hE0, 8'h0E, 8'h0F, 8'h7E, 8'hFC, 8'h00, 8'h00};
    logic [7:0] sGo [10] = '{8'hFF, 8'h00, 8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hFF, 8'hFE, 8'h05, 8'h20};
    logic [7:0] sPo [10] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] g, input logic [7:0] p);
        valid1 = v;
        gi1    = g;
        pi1    = p;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ready1 = 1'b1; ready2 = 1'b1;
        valid2 = 1'b0; gi2 = 8'h00; pi2 = 8'h00; ci1 = 1'b0; ci2 = 2'b00;
        applyStimulus(1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("rst_valid", 8'(validOut1), 8'h00);
        checkOutput("rst_go", go1, 8'h00);
        checkOutput("rst_po", po1, 8'h00);
        checkOutput("rst_ready", 8'(rdyOut1), 8'h01);
        checkOutput("rst_ready2", 8'(rdyOut2), 8'h01);

        // Latency: one operand, valid_o rises three edges after acceptance.
        applyStimulus(1'b1, 8'h01, 8'hFE);
        #1 checkOutput("lat_ready", 8'(rdyOut1), 8'h01);
        nextCycle(); applyStimulus(1'b0, 8'h00, 8'h00);
        #1 checkOutput("lat_v1", 8'(validOut1), 8'h00);
        nextCycle(); #1 checkOutput("lat_v2", 8'(validOut1), 8'h00);
        nextCycle(); #1;
        checkOutput("lat_v3", 8'(validOut1), 8'h01);
        checkOutput("lat_go", go1, 8'hFF);
        checkOutput("lat_po", po1, 8'h00);
        nextCycle();

        // Back-to-back stream of ten operands.
        for (int c = 0; c < 14; c++) begin
            nextCycle();
            if (c < 10) applyStimulus(1'b1, sG[c], sP[c]);
            else        applyStimulus(1'b0, 8'h00, 8'h00);
            #1;
            if (c < 10) checkOutput($sformatf("stream_ready%0d", c), 8'(rdyOut1), 8'h01);
            if (c >= 3 && c < 13) begin
                checkOutput($sformatf("stream_valid%0d", c - 3), 8'(validOut1), 8'h01);
                checkOutput($sformatf("stream_go%0d", c - 3), go1, sGo[c - 3]);
                checkOutput($sformatf("stream_po%0d", c - 3), po1, sPo[c - 3]);
            end else begin
                checkOutput($sformatf("stream_idle%0d", c), 8'(validOut1), 8'h00);
            end
        end

        // Backpressure: three entries pack, fourth is refused, output held.
        nextCycle(); ready1 = 1'b0; applyStimulus(1'b1, 8'h03, 8'h00);
        #1 checkOutput("bp_ready0", 8'(rdyOut1), 8'h01);
        nextCycle(); applyStimulus(1'b1, 8'h00, 8'hFF);
        #1 checkOutput("bp_ready1", 8'(rdyOut1), 8'h01);
        nextCycle(); applyStimulus(1'b1, 8'h40, 8'h80);
        #1 checkOutput("bp_ready2", 8'(rdyOut1), 8'h01);
        for (int c = 3; c < 5; c++) begin
            nextCycle(); applyStimulus(1'b1, 8'h11, 8'h00);
            #1;
            checkOutput($sformatf("bp_full%0d", c), 8'(rdyOut1), 8'h00);
            checkOutput($sformatf("bp_valid%0d", c), 8'(validOut1), 8'h01);
            checkOutput($sformatf("bp_hold_go%0d", c), go1, 8'h03);
            checkOutput($sformatf("bp_hold_po%0d", c), po1, 8'h00);
        end
        nextCycle(); applyStimulus(1'b0, 8'h00, 8'h00); ready1 = 1'b1;
        #1 checkOutput("bp_out0_go", go1, 8'h03);
        nextCycle(); #1;
        checkOutput("bp_out1_go", go1, 8'h00);
        checkOutput("bp_out1_po", po1, 8'hFF);
        nextCycle(); #1;
        checkOutput("bp_out2_valid", 8'(validOut1), 8'h01);
        checkOutput("bp_out2_go", go1, 8'hC0);
        nextCycle(); #1 checkOutput("bp_drained", 8'(validOut1), 8'h00);

        // Flush with two entries in flight and a new operand offered.
        nextCycle(); ready1 = 1'b0; applyStimulus(1'b1, 8'h01, 8'hFE);
        #1 checkOutput("fl_ready0", 8'(rdyOut1), 8'h01);
        nextCycle(); applyStimulus(1'b1, 8'h00, 8'hFF);
        #1 checkOutput("fl_ready1", 8'(rdyOut1), 8'h01);
        nextCycle(); flush = 1'b1; applyStimulus(1'b1, 8'hFF, 8'h00);
        #1 checkOutput("fl_ready_forced", 8'(rdyOut1), 8'h00);
        for (int c = 0; c < 5; c++) begin
            nextCycle(); flush = 1'b0; ready1 = 1'b1; applyStimulus(1'b0, 8'h00, 8'h00);
            #1 checkOutput($sformatf("fl_empty%0d", c), 8'(validOut1), 8'h00);
        end

        // Two lanes: no carry crosses the lane boundary.
        nextCycle(); valid2 = 1'b1; gi2 = 8'h08; pi2 = 8'hF0;
        #1 checkOutput("lane_ready", 8'(rdyOut2), 8'h01);
        nextCycle(); gi2 = 8'h01; pi2 = 8'hFE;
        nextCycle(); valid2 = 1'b0;
        #1;
        checkOutput("lane_a_valid", 8'(validOut2), 8'h01);
        checkOutput("lane_a_go", go2, 8'h08);
        checkOutput("lane_a_po", po2, 8'hF0);
        nextCycle(); #1;
        checkOutput("lane_b_go", go2, 8'h0F);
        checkOutput("lane_b_po", po2, 8'hF0);

`ifdef PREFIX_AND_OR_PIPE_CIN_EN
        // Carry-in travels with its operand through every stage.
        nextCycle(); ci1 = 1'b1; applyStimulus(1'b1, 8'h00, 8'hFF);
        nextCycle(); ci1 = 1'b0; applyStimulus(1'b1, 8'h00, 8'hFF);
        nextCycle(); ci1 = 1'b1; applyStimulus(1'b0, 8'h00, 8'h00);
        nextCycle(); #1;
        checkOutput("cin1_go", go1, 8'hFF);
        checkOutput("cin1_po", po1, 8'hFF);
        nextCycle(); #1;
        checkOutput("cin0_go", go1, 8'h00);
        nextCycle(); ci1 = 1'b0;
`endif

        // Asynchronous reset in the middle of a stream.
        for (int c = 0; c < 4; c++) begin
            nextCycle(); applyStimulus(1'b1, 8'h01, 8'hFE);
        end
        #1;
        checkOutput("mid_valid_pre", 8'(validOut1), 8'h01);
        checkOutput("mid_go_pre", go1, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 8'(validOut1), 8'h00);
        checkOutput("mid_rst_go", go1, 8'h00);
        checkOutput("mid_rst_po", po1, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00);
        #2 rst_n = 1'b1;
        nextCycle(); #1;
        checkOutput("mid_ready_after", 8'(rdyOut1), 8'h01);
        checkOutput("mid_valid_after", 8'(validOut1), 8'h00);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/prefix_and_or_pipe.md
# prefix_and_or_pipe

Pipelined, lane-segmented parallel-prefix AND-OR network for carry computation in wide binary adders. It builds the same group generate/propagate prefix as the combinational prefix structures, but inserts pipeline registers every `levelsPerStage` prefix levels and moves operands with a valid/ready handshake. Multi-cycle adders and SIMD adders in the arithmetic library use it where one combinational prefix level chain does not meet timing.

## Interface
- `width`, 32: word width; must be divisible by `lanes`.
- `lanes`, 1: number of independent lanes. The prefix restarts at every lane boundary (lane width `w = width/lanes`, a power of two, ≥ 2).
- `speed`, `lau_pkg::FAST`: prefix topology per lane. FAST is Sklansky, MEDIUM is Brent-Kung, SLOW is serial.
- `levelsPerStage`, 1: number of prefix levels between pipeline registers; ≥ 1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous flush; clears all in-flight entries.
- `valid_i`  in  1  input operand valid.
- `ready_o`  out  1  block can accept an operand this cycle.
- `GI`  in  width  generate in.
- `PI`  in  width  propagate in.
- `CI`  in  lanes  per-lane carry-in; present only with the carry-in macro.
- `valid_o`  out  1  output valid.
- `ready_i`  in  1  downstream accepts the output.
- `GO`  out  width  prefix generate out (carries).
- `PO`  out  width  prefix propagate out.

## Operation
- Per lane `j`, bit `i` (local index `0..w-1`):
  - `PO[i] = AND(PI[0..i])`.
  - `GO[i] = GI[i] | PI[i]&GO[i-1]`, with `GO[-1] = 0`.
  - No term crosses a lane boundary.
- Level count per lane:
  - `L = log2(w)` for FAST.
  - `L = 2·log2(w)−1` for MEDIUM.
  - SLOW is treated as one level group, so `L = 1`.
- Stage count `S = ceil(L/levelsPerStage)`. The last register drives `GO`/`PO` directly.
- Each stage holds a valid bit plus its G/P word (and the CI word when enabled).
  - Stage `k` loads when it is empty or when its content moves to stage `k+1` in the same cycle.
  - The last stage drains when `valid_o & ready_i`.
- `ready_o` = stage 0 empty, or stage 0 advancing this cycle. This is a combinational ready chain from `ready_i`.
- An input transfer happens when `valid_i & ready_o`. An output transfer happens when `valid_o & ready_i`.
- Ordering is strict FIFO. Full throughput is one operand per cycle when `ready_i` is held at 1.
- When `ready_i = 0`, entries pack toward the output. Up to `S` operands are held with no loss.
- `GO`/`PO` must remain stable while `valid_o & !ready_i`.
- `flush_i = 1`:
  - All valid bits clear on the next edge.
  - `ready_o` is forced to 0 in that cycle, so `valid_i` is ignored.
  - `valid_o` is 0 from the next cycle.
- Flush and output transfer in the same cycle: the output transfer completes, then the block is empty.

## Timing
- Latency is `S` cycles from input transfer to `valid_o`, when `ready_i = 1`.
  - Example: `width=8`, FAST, `levelsPerStage=1` gives `S = 3`.
- Reset values: all valid bits 0, all data registers 0. So after reset `valid_o=0`, `GO=0`, `PO=0`, `ready_o=1` (with `flush_i=0`).
- Reset asserted mid-operation discards all entries immediately and asynchronously.
- The combinational path from `ready_i` to `ready_o` is at most `S` AND-OR gates.

## Configuration
- Macro: `PREFIX_AND_OR_PIPE_CIN_EN`.
- Defined:
  - The `CI` port exists and travels with its operand through every stage.
  - The final stage outputs `GO[i] | PO[i]&CI[j]` for lane `j`.
- Undefined:
  - There is no `CI` port and no CI registers.
  - `GO` is the pure prefix generate.

## Structure
- `lau_pkg` gets:
  - `speed_e` (already present).
  - Functions `prefix_levels(w, speed)` and `prefix_stages(w, speed, levelsPerStage)`, shared with future pipelined adders.
- Sub-module `prefix_pipe_stage`: one register stage holding valid, G, P and optional CI, with its load/hold handshake logic.
  - The top module instantiates `S` of these.
  - Between stages it places the combinational prefix levels for that level range, per lane.

## Test plan
- `width=8`, FAST, `levelsPerStage=1`, one lane.
  - Input `GI=8'h01`, `PI=8'hFE`, `ready_i=1`.
  - Required: `valid_o` rises exactly 3 cycles later with `GO=8'hFF`, `PO=8'h00`.
- Same configuration, with a different input per cycle for 10 cycles.
  - Required: 10 outputs in order, back-to-back, with no `ready_o` deassertion.
- Hold `ready_i=0` and push operands.
  - Required: exactly 3 are accepted, then `ready_o=0`, and `GO`/`PO` stay stable.
  - Then raise `ready_i`: all 3 emerge in order.
- `lanes=2`, `width=8`, `GI=8'h08`, `PI=8'hF0`.
  - Required: `GO=8'h08`. The lane-0 generate must not propagate into lane 1; lane 1 has no generate.
- Assert `flush_i` with 2 entries in flight and `valid_i=1`.
  - Required: `ready_o=0` that cycle, `valid_o=0` next cycle, and the dropped operand never appears.
- With `PREFIX_AND_OR_PIPE_CIN_EN`: `GI=0`, `PI=8'hFF`, `CI=1`.
  - Required: `GO=8'hFF`. With `CI=0`: `GO=8'h00`.
- Reset asserted mid-stream.
  - Required: `valid_o`, `GO` and `PO` are 0 immediately, and `ready_o=1` after release.
